// File: rtl/mlp_feature_loader.sv
// mlp_feature_loader
// Front-end for the 21x4-bit combinational printed MLP classifier.
// Features arrive one per valid/ready beat and are assembled into the flat
// classifier input vector. That vector is then held for SETTLE_CYC cycles so
// the classifier output can settle. The class index is registered and offered
// on a valid/ready result port.
//
// Optional build macro: FRAME_CHECK_EN
//   When it is defined, every accepted beat is checked against feat_last.
//   A mismatch drops the beat, pulses frame_err and restarts the frame.
//   When it is undefined, feat_last is ignored and frame_err is held at 0.
module mlp_feature_loader #(
  parameter int N_FEAT     = 21,
  parameter int FEAT_W     = 4,
  parameter int CLS_W      = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       feat_valid,
  output logic                       feat_ready,
  input  logic [FEAT_W-1:0]          feat_data,
  input  logic                       feat_last,
  output logic [N_FEAT*FEAT_W-1:0]   clf_inp,
  input  logic [CLS_W-1:0]           clf_out,
  output logic                       cls_valid,
  input  logic                       cls_ready,
  output logic [CLS_W-1:0]           cls_data,
  output logic                       frame_err
);

  localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(N_FEAT - 1);
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYC);
  localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t                      state_r;
  state_t                      state_s;
  logic [CNT_W-1:0]            cnt_r;
  logic [CNT_W-1:0]            cnt_s;
  logic [SET_W-1:0]            settle_r;
  logic [SET_W-1:0]            settle_s;
  logic [N_FEAT*FEAT_W-1:0]    inp_r;
  logic [CLS_W-1:0]            cls_data_r;
  logic                        cls_valid_r;
  logic                        feat_ready_r;
  logic                        frame_err_r;

  logic                        accept_s;
  logic                        beat_err_s;
  logic                        write_s;
  logic                        err_s;
  logic                        capture_s;
  logic                        release_s;

  assign accept_s = feat_valid & feat_ready_r;

`ifdef FRAME_CHECK_EN
  // A beat is malformed when its last flag disagrees with its slot position.
  assign beat_err_s = feat_last ^ (cnt_r == LAST_IDX);
`else
  // Without frame checking a frame ends purely on the beat count.
  logic unused_last_s;
  assign unused_last_s = feat_last;
  assign beat_err_s    = 1'b0;
`endif

  // Next-state logic: beat counting, settle countdown and result handshake.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    settle_s  = settle_r;
    write_s   = 1'b0;
    err_s     = 1'b0;
    capture_s = 1'b0;
    release_s = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (accept_s) begin
          if (beat_err_s) begin
            // Malformed frame: drop this beat and restart at feature 0.
            err_s = 1'b1;
            cnt_s = '0;
          end else begin
            write_s = 1'b1;
            if (cnt_r == LAST_IDX) begin
              cnt_s    = '0;
              settle_s = SETTLE_INIT;
              state_s  = ST_SETTLE;
            end else begin
              cnt_s = cnt_r + CNT_W'(1);
            end
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_SETTLE: begin
        // The count reaching 1 marks the last settle cycle; sample then.
        if (settle_r <= SETTLE_ONE) begin
          capture_s = 1'b1;
          settle_s  = '0;
          state_s   = ST_HOLD;
        end else begin
          settle_s = settle_r - SETTLE_ONE;
        end
      end
      ST_HOLD: begin
        if (cls_ready) begin
          release_s = 1'b1;
          state_s   = ST_LOAD;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s  = ST_LOAD;
        cnt_s    = '0;
        settle_s = '0;
      end
    endcase
  end

  // Control registers: state, counters, ready, result and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_LOAD;
      cnt_r        <= '0;
      settle_r     <= '0;
      feat_ready_r <= 1'b1;
      cls_valid_r  <= 1'b0;
      cls_data_r   <= '0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      settle_r     <= settle_s;
      feat_ready_r <= (state_s == ST_LOAD);
      frame_err_r  <= err_s;
      if (capture_s) begin
        cls_data_r  <= clf_out;
        cls_valid_r <= 1'b1;
      end else if (release_s) begin
        cls_valid_r <= 1'b0;
      end
    end
  end

  // Feature slots: only reset clears them; each accepted beat overwrites its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      inp_r <= '0;
    end else begin
      for (int k = 0; k < N_FEAT; k++) begin
        if (write_s && (cnt_r == CNT_W'(k))) begin
          inp_r[k*FEAT_W +: FEAT_W] <= feat_data;
        end
      end
    end
  end

  assign feat_ready = feat_ready_r;
  assign clf_inp    = inp_r;
  assign cls_valid  = cls_valid_r;
  assign cls_data   = cls_data_r;
  assign frame_err  = frame_err_r;

endmodule
